// File: rtl/data_memory_pkg.sv
// Shared constants and FSM encoding for the byte-wide data memory.
// Used by the memory itself and by CPU-side benches.
package data_memory_pkg;

   localparam int unsigned DMEM_DEPTH   = 256;
   localparam int unsigned DMEM_AW      = 8;
   localparam int unsigned DMEM_LATENCY = 5;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACCESS   = 2'd1,
      COMPLETE = 2'd2
   } state_t;

endpackage

// File: rtl/data_memory_if.sv
// CPU <-> data memory request bus.
// The CPU holds read/write until busywait drops.
interface data_memory_if;

   logic       read;
   logic       write;
   logic [7:0] address;
   logic [7:0] writedata;
   logic [7:0] readdata;
   logic       busywait;

   modport master (
      output read, write, address, writedata,
      input  readdata, busywait
   );

   modport slave (
      input  read, write, address, writedata,
      output readdata, busywait
   );

endinterface

// File: rtl/data_memory_array.sv
// 256 x 8 storage: synchronous write, asynchronous read.
// clr wipes every byte on the clock edge and takes priority over we.
module dmem_array
   import data_memory_pkg::*;
(
   input  logic       clk,
   input  logic       clr,
   input  logic       we,
   input  logic [7:0] waddr,
   input  logic [7:0] wdata,
   input  logic [7:0] raddr,
   output logic [7:0] rdata
);

   logic [7:0] mem [DMEM_DEPTH];

   assign rdata = mem[raddr];

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < DMEM_DEPTH; i++) begin
            mem[i] <= 8'h00;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

endmodule

// File: rtl/data_memory.sv
// Multi-cycle data memory: busywait stalls the CPU for LATENCY cycles.
// Define DMEM_CLEAR_ON_RESET_EN to wipe the storage on every reset edge.
module data_memory
   import data_memory_pkg::*;
#(
   parameter int unsigned LATENCY = DMEM_LATENCY
) (
   input  logic          clk,
   input  logic          reset,
   data_memory_if.slave  bus
);

   state_t     state;
   state_t     state_nxt;
   logic [3:0] cnt;
   logic [3:0] cnt_nxt;
   logic       busy;
   logic       req;
   logic       start;
   logic       done;
   logic       mem_we;
   logic       clr;
   logic [7:0] lat_addr;
   logic [7:0] lat_data;
   logic       lat_wr;
   logic [7:0] rdata;

   assign req    = bus.read | bus.write;
   assign start  = (state == IDLE) && req;
   assign done   = (state == ACCESS) && (cnt == 4'd0);
   assign mem_we = done && lat_wr && reset;

`ifdef DMEM_CLEAR_ON_RESET_EN
   assign clr = ~reset;
`else
   assign clr = 1'b0;
`endif

   // The IDLE request cycle counts as the first stall cycle.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      busy      = 1'b0;
      unique case (state)
         IDLE: begin
            if (req) begin
               busy      = 1'b1;
               state_nxt = ACCESS;
               cnt_nxt   = 4'(LATENCY - 2);
            end
         end
         ACCESS: begin
            busy = 1'b1;
            if (cnt == 4'd0) begin
               state_nxt = COMPLETE;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         COMPLETE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign bus.busywait = reset & busy;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= IDLE;
         cnt          <= 4'd0;
         bus.readdata <= 8'h00;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (done && !lat_wr) begin
            bus.readdata <= rdata;
         end
      end
   end

   // Write wins when read and write arrive together.
   always_ff @(posedge clk) begin
      if (start) begin
         lat_addr <= bus.address;
         lat_data <= bus.writedata;
         lat_wr   <= bus.write;
      end
   end

   dmem_array u_array (
      .clk   (clk),
      .clr   (clr),
      .we    (mem_we),
      .waddr (lat_addr),
      .wdata (lat_data),
      .raddr (lat_addr),
      .rdata (rdata)
   );

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory at LATENCY 5 and LATENCY 2.
// Each completed access is checked for readdata and stall length.
module tb_data_memory;

   import data_memory_pkg::*;

   typedef struct {
      string      name;
      logic [7:0] rd;
      int         len;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   data_memory_if bus_a ();
   data_memory_if bus_b ();

   data_memory #(.LATENCY(5)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a.slave)
   );

   data_memory #(.LATENCY(2)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b.slave)
   );

   exp_t q_a[$];
   exp_t q_b[$];
   int   errors = 0;
   int   checks = 0;
   int   run_a  = 0;
   int   run_b  = 0;

   function automatic void chk(string n, int act, int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", n, act, req);
      end
   endfunction

   function automatic void chk8(string n, logic [7:0] act, logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, req);
      end
   endfunction

   // A falling busywait with reset high marks one completed access.
   always @(negedge clk) begin
      exp_t e;
      if (reset && bus_a.busywait) begin
         run_a++;
      end else begin
         if (reset && run_a > 0) begin
            if (q_a.size() == 0) begin
               chk("a_unexpected_access", run_a, 0);
            end else begin
               e = q_a.pop_front();
               chk8({e.name, "_rd"}, bus_a.readdata, e.rd);
               chk({e.name, "_len"}, run_a, e.len);
            end
         end
         run_a = 0;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (reset && bus_b.busywait) begin
         run_b++;
      end else begin
         if (reset && run_b > 0) begin
            if (q_b.size() == 0) begin
               chk("b_unexpected_access", run_b, 0);
            end else begin
               e = q_b.pop_front();
               chk8({e.name, "_rd"}, bus_b.readdata, e.rd);
               chk({e.name, "_len"}, run_b, e.len);
            end
         end
         run_b = 0;
      end
   end

   task automatic set_req(int sel, logic rd, logic wr,
                          logic [7:0] a, logic [7:0] d);
      if (sel == 0) begin
         bus_a.read      = rd;
         bus_a.write     = wr;
         bus_a.address   = a;
         bus_a.writedata = d;
      end else begin
         bus_b.read      = rd;
         bus_b.write     = wr;
         bus_b.address   = a;
         bus_b.writedata = d;
      end
   endtask

   function automatic logic busy(int sel);
      return (sel == 0) ? bus_a.busywait : bus_b.busywait;
   endfunction

   task automatic wait_done(int sel);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy(sel) && n < 50);
      if (n >= 50) chk("busywait_timeout", n, 0);
   endtask

   task automatic access(int sel, logic rd, logic wr, logic [7:0] a,
                         logic [7:0] d, string name,
                         logic [7:0] exp_rd, int len);
      exp_t e;
      e = '{name, exp_rd, len};
      if (sel == 0) q_a.push_back(e);
      else          q_b.push_back(e);
      @(posedge clk); #1;
      set_req(sel, rd, wr, a, d);
      wait_done(sel);
      @(posedge clk); #1;
      set_req(sel, 1'b0, 1'b0, 8'h00, 8'h00);
   endtask

   initial begin
      exp_t e;
      set_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
      set_req(1, 1'b0, 1'b1, 8'h10, 8'h00);
      @(negedge clk);
      chk("reset_busy_a", int'(bus_a.busywait), 0);
      chk("reset_busy_b", int'(bus_b.busywait), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk8("reset_rd_a", bus_a.readdata, 8'h00);
      chk8("reset_rd_b", bus_b.readdata, 8'h00);
      @(posedge clk); #1;
      reset = 1'b1;
      set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
      set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);

      access(0, 1'b0, 1'b1, 8'h10, 8'hA5, "wr10", 8'h00, 5);
      access(0, 1'b1, 1'b0, 8'h10, 8'h00, "rd10", 8'hA5, 5);

      // stale read held through COMPLETE and one cycle beyond
      e = '{"stale1", 8'hA5, 5};
      q_a.push_back(e);
      e = '{"stale2", 8'hA5, 5};
      q_a.push_back(e);
      @(posedge clk); #1;
      set_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
      wait_done(0);
      @(negedge clk);
      chk("stale_restart_busy", int'(bus_a.busywait), 1);
      @(posedge clk); #1;
      set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
      wait_done(0);

      access(0, 1'b0, 1'b1, 8'h31, 8'h11, "wr31", 8'hA5, 5);

      // churn address and data while the write is in flight
      e = '{"churn_wr30", 8'hA5, 5};
      q_a.push_back(e);
      @(posedge clk); #1;
      set_req(0, 1'b0, 1'b1, 8'h30, 8'h5A);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         set_req(0, 1'b0, 1'b1, 8'h31, 8'hE0 + 8'(i));
      end
      wait_done(0);
      @(posedge clk); #1;
      set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
      access(0, 1'b1, 1'b0, 8'h30, 8'h00, "rd30", 8'h5A, 5);
      access(0, 1'b1, 1'b0, 8'h31, 8'h00, "rd31", 8'h11, 5);

      access(0, 1'b1, 1'b1, 8'hFF, 8'h77, "rw_ff", 8'h11, 5);
      access(0, 1'b1, 1'b0, 8'hFF, 8'h00, "rdff", 8'h77, 5);

      // reset asserted in the third ACCESS cycle of a write
      access(0, 1'b0, 1'b1, 8'h20, 8'hC3, "wr20", 8'h77, 5);
      @(posedge clk); #1;
      set_req(0, 1'b0, 1'b1, 8'h20, 8'h3C);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midop_busy", int'(bus_a.busywait), 0);
      chk8("midop_rd", bus_a.readdata, 8'h00);
      @(posedge clk); #1;
      reset = 1'b1;
      set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
`ifdef DMEM_CLEAR_ON_RESET_EN
      access(0, 1'b1, 1'b0, 8'h20, 8'h00, "rd20", 8'h00, 5);
`else
      access(0, 1'b1, 1'b0, 8'h20, 8'h00, "rd20", 8'hC3, 5);
`endif

      access(1, 1'b0, 1'b1, 8'h00, 8'h42, "b_wr00", 8'h00, 2);
      access(1, 1'b1, 1'b0, 8'h00, 8'h00, "b_rd00", 8'h42, 2);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("a_queue_left", q_a.size(), 0);
      chk("b_queue_left", q_b.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 The module SHALL have one parameter: LATENCY, default 5, number of cycles BUSYWAIT is held high per access (legal range 2..15).
REQ-002 Port CLK  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 Port RESET  input  1  synchronous, active-low reset, sampled on the rising edge of CLK.
REQ-004 Port READ  input  1  read request from the CPU, level-held until the CPU advances.
REQ-005 Port WRITE  input  1  write request from the CPU, level-held until the CPU advances.
REQ-006 Port ADDRESS  input  8  byte address (the CPU ALU result).
REQ-007 Port WRITEDATA  input  8  byte to store (the CPU register OUT1).
REQ-008 Port READDATA  output  8  registered byte returned for reads.
REQ-009 Port BUSYWAIT  output  1  stall to the CPU; high while an access is outstanding.

Function
REQ-010 Storage SHALL be 256 x 8-bit, indexed directly by ADDRESS.
REQ-011 The FSM SHALL have states IDLE, ACCESS and COMPLETE.
REQ-012 BUSYWAIT SHALL be combinational: high when in IDLE with READ|WRITE high, high throughout ACCESS, and low in COMPLETE and in IDLE with no request.
REQ-013 In IDLE with READ|WRITE high, the next edge SHALL latch ADDRESS, WRITEDATA and the operation, load the counter with LATENCY-2, and enter ACCESS.
REQ-014 In ACCESS the counter SHALL decrement each cycle; when it reaches 0, the next edge SHALL complete the access and enter COMPLETE, giving exactly LATENCY cycles of BUSYWAIT high.
REQ-015 Completing a read SHALL load READDATA with mem[latched address] on the completing edge.
REQ-016 Completing a write SHALL store the latched WRITEDATA at mem[latched address] on the completing edge; READDATA SHALL be unchanged.
REQ-017 COMPLETE SHALL last one cycle with BUSYWAIT low, ignore READ/WRITE (the CPU's stale request), and then return to IDLE.
REQ-018 READ and WRITE both high SHALL be executed as a write only; READDATA SHALL be unchanged.
REQ-019 Changes on the inputs during ACCESS SHALL have no effect; only the latched values are used.
REQ-020 READDATA SHALL hold its last value at all times other than a read completion or reset.

Reset
REQ-021 With RESET low at an edge, the module SHALL enter IDLE, set the counter to 0 and set READDATA to 8'h00.
REQ-022 While RESET is low, BUSYWAIT SHALL be 0 regardless of READ/WRITE.
REQ-023 A reset during ACCESS SHALL abort the access: no memory write and no READDATA update.
REQ-024 Memory contents SHALL be unaffected by reset unless REQ-025 applies.

Configuration
REQ-025 With DMEM_CLEAR_ON_RESET_EN defined, every reset edge SHALL clear all 256 bytes to 8'h00.
REQ-026 Without DMEM_CLEAR_ON_RESET_EN, contents SHALL persist across reset and SHALL be X until first written.

Structure
REQ-027 The FSM state encoding (IDLE=2'd0, ACCESS=2'd1, COMPLETE=2'd2), the DMEM_DEPTH=256 constant and the default latency SHALL live in a shared package / include file used by the CPU-side bench.
REQ-028 The storage array SHALL be a sub-module dmem_array: synchronous write port, asynchronous read port, and an optional clear input.
REQ-029 The FSM, counter and latches SHALL live in data_memory.

Verification
REQ-030 Write then read: LATENCY=5, WRITE at addr 8'h10, data 8'hA5, then READ at 8'h10 -> BUSYWAIT high 5 cycles per access, then 1 cycle low; READDATA=8'hA5 after the read completes.
REQ-031 Stale request: hold READ high through COMPLETE and one more cycle -> exactly one new access starts, from IDLE, in the cycle after COMPLETE; the COMPLETE cycle itself starts nothing.
REQ-032 Reset mid-op: WRITE 8'h3C to 8'h20, RESET low in cycle 3 of ACCESS -> BUSYWAIT 0 and READDATA 8'h00 next cycle; a later read of 8'h20 returns the prior value (or 8'h00 with DMEM_CLEAR_ON_RESET_EN).
REQ-033 Simultaneous READ and WRITE at 8'hFF with data 8'h77 -> memory[8'hFF]=8'h77 and READDATA unchanged.
REQ-034 Input churn: change ADDRESS/WRITEDATA every cycle during ACCESS -> only the values latched on the first edge are written.
REQ-035 Boundary latency: LATENCY=2, read of address 8'h00 -> BUSYWAIT high exactly 2 cycles.
